// File: rtl/if_id_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_pkg
//  Description : Shared constants and types for the IF/ID elastic buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package if_id_pkg;

    // Instruction word width
    localparam int INSTR_W = 32;

    // Default PC width; the buffer re-declares its entry type with its own N
    localparam int PC_W_DEFAULT = 32;

    // Occupancy encodings
    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    // One fetched beat at the default PC width
    typedef struct packed {
        logic [PC_W_DEFAULT-1:0] pc;
        logic [INSTR_W-1:0]      instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_id_entry_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_entry_reg
//  Description : Load-enable storage register for one buffered {pc, instr}
//                beat, synchronously cleared by the active-low reset.
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_entry_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Capture the incoming beat when enabled; reset clears to zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_buffer
//  Description : Two-entry elastic buffer between fetch and decode with a
//                flush for branch/jump redirects. in_ready depends only on
//                the occupancy, so out_ready never reaches in_ready
//                combinationally.
//                Optional feature macro: IF_ID_STALL_CNT_EN adds a wrapping
//                counter of cycles where decode stalls a valid head beat.
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_buffer
    import if_id_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_pc,
    output logic [INSTR_W-1:0] out_instr
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt
`endif
);

    typedef struct packed {
        logic [N-1:0]       pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    localparam int ENTRY_W = N + INSTR_W;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("if_id_buffer: CNT_W must be at least 1");
    end

    logic [1:0] count_q;
    logic [1:0] count_d;
    entry_t     head_q;
    entry_t     tail_q;
    entry_t     head_d;
    entry_t     in_beat;
    logic       head_en;
    logic       tail_en;
    logic       push;
    logic       pop;

    assign in_beat   = '{pc: in_pc, instr: in_instr};
    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != CNT_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next occupancy and entry load control; flush empties the buffer and
    // suppresses any load so a beat arriving in the flush cycle is dropped
    always_comb begin
        count_d = count_q;
        head_en = 1'b0;
        tail_en = 1'b0;
        head_d  = in_beat;
        if (flush) begin
            count_d = CNT_EMPTY;
        end else begin
            case (count_q)
                CNT_EMPTY: begin
                    if (push) begin
                        head_en = 1'b1;
                        count_d = CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (push && pop) begin
                        head_en = 1'b1;
                    end else if (push) begin
                        tail_en = 1'b1;
                        count_d = CNT_FULL;
                    end else if (pop) begin
                        count_d = CNT_EMPTY;
                    end
                end
                CNT_FULL: begin
                    if (pop) begin
                        head_en = 1'b1;
                        head_d  = tail_q;
                        count_d = CNT_ONE;
                    end
                end
                default: begin
                    count_d = CNT_EMPTY;
                end
            endcase
        end
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= CNT_EMPTY;
        end else begin
            count_q <= count_d;
        end
    end

    if_id_entry_reg #(.W(ENTRY_W)) u_head (
        .clk  (clk),
        .rst  (rst),
        .en_i (head_en),
        .d_i  (head_d),
        .q_o  (head_q)
    );

    if_id_entry_reg #(.W(ENTRY_W)) u_tail (
        .clk  (clk),
        .rst  (rst),
        .en_i (tail_en),
        .d_i  (in_beat),
        .q_o  (tail_q)
    );

    // Stale entry contents stay hidden whenever the buffer is empty
    assign out_pc    = out_valid ? head_q.pc    : '0;
    assign out_instr = out_valid ? head_q.instr : '0;

`ifdef IF_ID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Count cycles where decode holds off a valid head beat; flush has no effect
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_buffer
//  Description : Scoreboard testbench for if_id_buffer.
//                Optional feature macro: IF_ID_STALL_CNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_id_buffer;

    localparam int N     = 32;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_pc;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_pc;
    logic [31:0]      out_instr;
`ifdef IF_ID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    typedef struct packed {
        logic [N-1:0] pc;
        logic [31:0]  instr;
    } beat_t;

    beat_t            sb[$];
    int               n_vec = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] exp_stall = '0;

    always #5 clk = ~clk;

    if_id_buffer #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr)
`ifdef IF_ID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model
    task automatic cycle();
        beat_t h;
        int    sz;
        bit    push;
        bit    pop;
        @(negedge clk);
        sz = sb.size();
        h  = (sz != 0) ? sb[0] : '0;
        chk("out_valid", 64'(out_valid), 64'(sz != 0));
        chk("in_ready",  64'(in_ready),  64'(sz != 2));
        chk("out_pc",    64'(out_pc),    64'(h.pc));
        chk("out_instr", 64'(out_instr), 64'(h.instr));
`ifdef IF_ID_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`endif
        push = in_valid && (sz != 2);
        pop  = (sz != 0) && out_ready;
        if (!rst) begin
            sb.delete();
            exp_stall = '0;
        end else begin
            if ((sz != 0) && !out_ready) exp_stall = exp_stall + 1'b1;
            if (flush) begin
                sb.delete();
            end else begin
                if (pop)  void'(sb.pop_front());
                if (push) sb.push_back('{pc: in_pc, instr: in_instr});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        cycle();
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h99;
        in_instr  = 32'h99;
        out_ready = 1'b0;

        // Reset held with a valid beat offered
        cycle();
        cycle();
        rst = 1'b1;

        // Streaming
        drive(1'b1, 32'h0, 32'hA, 1'b1, 1'b0);
        drive(1'b1, 32'h4, 32'hB, 1'b1, 1'b0);
        drive(1'b1, 32'h8, 32'hC, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Backpressure, including a blocked offer while full
        drive(1'b1, 32'h10, 32'h1010, 1'b0, 1'b0);
        drive(1'b1, 32'h14, 32'h1414, 1'b0, 1'b0);
        drive(1'b1, 32'h18, 32'h1818, 1'b0, 1'b0);
        drive(1'b0, 32'h0,  32'h0,    1'b1, 1'b0);
        drive(1'b0, 32'h0,  32'h0,    1'b1, 1'b0);
        drive(1'b0, 32'h0,  32'h0,    1'b1, 1'b0);

        // Flush while full with a beat offered; pop in flush cycle
        drive(1'b1, 32'h20, 32'h2020, 1'b0, 1'b0);
        drive(1'b1, 32'h24, 32'h2424, 1'b0, 1'b0);
        drive(1'b1, 32'h28, 32'h2828, 1'b1, 1'b1);
        drive(1'b1, 32'h40, 32'h4040, 1'b1, 1'b0);
        drive(1'b0, 32'h0,  32'h0,    1'b1, 1'b0);
        drive(1'b0, 32'h0,  32'h0,    1'b1, 1'b0);

        // Flush from one entry with a push and no pop
        drive(1'b1, 32'h30, 32'h3030, 1'b0, 1'b0);
        drive(1'b1, 32'h34, 32'h3434, 1'b0, 1'b1);
        drive(1'b0, 32'h0,  32'h0,    1'b1, 1'b0);

        // Reset mid-operation with buffer full
        drive(1'b1, 32'h50, 32'h5050, 1'b0, 1'b0);
        drive(1'b1, 32'h54, 32'h5454, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b1, 32'h58, 32'h5858, 1'b1, 1'b0);
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

`ifdef IF_ID_STALL_CNT_EN
        // Stall counting: 5 cycles, flush, then wrap with further stalls
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 32'h60, 32'h6060, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("stall_after_5", 64'(stall_cnt), 64'd5);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        drive(1'b1, 32'h64, 32'h6464, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`endif

        // Random traffic with occasional flushes
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  N'($urandom) & ~N'(3),
                  32'($urandom),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
